pc_control: RTL and testbench
=============================

PC_CONTROL -- requirements
Module: pc_control

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000: PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port opcode  input  4  opcode of the instruction at current PC.
REQ-005 SHALL have port imm9  input  9  signed branch offset, in instruction words, for B.
REQ-006 SHALL have port br_target  input  16  register-sourced target for BR.
REQ-007 SHALL have port take_branch  input  1  branch decision for the current instruction; qualified only for B/BR.
REQ-008 SHALL have port stall  input  1  hold request; freezes PC and FSM when high.
REQ-009 SHALL have port pc  output  16  current PC (registered).
REQ-010 SHALL have port pc_plus2  output  16  pc + 2, combinational, for PCS and fall-through.
REQ-011 SHALL have port halted  output  1  high while in HALTED state (registered).

Function
REQ-012 SHALL implement two-state FSM: RUN, HALTED.
- RUN -> HALTED when opcode == 4'hF and stall == 0.
- HALTED -> HALTED until reset.
REQ-013 SHALL, in RUN with stall == 0, load next PC at the clock edge:
- opcode 4'hC and take_branch == 1: pc_plus2 + (sign_extend(imm9) << 1).
- opcode 4'hD and take_branch == 1: br_target.
- opcode 4'hF: pc (hold; PC stays on the HLT address).
- otherwise: pc_plus2.
REQ-014 SHALL ignore take_branch for all opcodes other than 4'hC/4'hD.
REQ-015 SHALL perform all PC arithmetic modulo 2^16; 16'hFFFE + 2 = 16'h0000, with no error indication.
REQ-016 SHALL ignore br_target bit 0 (force target LSB to 0).
REQ-017 SHALL, when stall == 1, hold pc and FSM state; stall takes priority over take_branch and HLT.
REQ-018 SHALL, in HALTED, hold pc regardless of all inputs; halted == 1.
REQ-019 SHALL have a redirect latency of one cycle: a taken branch sampled at edge N shows its target on pc after edge N.

Reset
REQ-020 SHALL, on rst assertion and independent of clk, set pc = RESET_PC, state = RUN, halted = 0, and the branch counter (if built) = 0.
REQ-021 SHALL, on reset mid-operation (including in HALTED or during stall), discard the pending next-PC; the first post-reset fetch is at RESET_PC.

Configuration
REQ-022 SHALL, with macro PC_CONTROL_BRANCH_COUNT_EN defined, add output taken_cnt (16) counting taken B/BR instructions.
- Increments on edges where state == RUN, stall == 0 and a branch redirect occurs.
- Saturates at 16'hFFFF.
REQ-023 SHALL, with PC_CONTROL_BRANCH_COUNT_EN undefined, have no taken_cnt port and no counter logic; all other behaviour is identical.

Structure
REQ-024 SHALL take opcode constants (OP_B = 4'hC, OP_BR = 4'hD, OP_PCS = 4'hE, OP_HLT = 4'hF) and the FSM state enum from shared package wisc_pkg.
REQ-025 SHALL instantiate one sub-module, pc_next_sel: combinational next-PC mux/adder, 16-bit; the FSM and registers remain in pc_control.

Verification
REQ-026 Reset: assert rst with RESET_PC = 0 -> pc = 16'h0000, halted = 0; after 3 non-branch cycles, pc = 16'h0006.
REQ-027 Taken B: pc = 16'h0010, opcode C, imm9 = 9'h1FE (-2), take_branch = 1 -> next pc = 16'h000E. Not-taken (take_branch = 0) -> 16'h0012.
REQ-028 BR: opcode D, br_target = 16'h1235, take_branch = 1 -> next pc = 16'h1234. Opcode 4'h0 with take_branch = 1 -> pc + 2.
REQ-029 Stall priority: stall = 1 with taken B for 2 cycles -> pc unchanged, counter unchanged; release -> redirect on the following edge, counter +1.
REQ-030 Halt: pc = 16'h0020, opcode F -> halted = 1 next cycle, pc stays 16'h0020 for 5 cycles with random inputs; rst asynchronous mid-cycle -> pc = 0, halted = 0 immediately.
REQ-031 Wrap/saturation: pc = 16'hFFFE, non-branch -> 16'h0000. With the macro defined, preload taken_cnt to 16'hFFFF via 65535 taken branches, take one more -> stays 16'hFFFF.

Source files
------------

// File: rtl/wisc_pkg.sv
// Shared opcode constants and PC-control FSM state type.
package wisc_pkg;

  localparam logic [3:0] OP_B   = 4'hC;
  localparam logic [3:0] OP_BR  = 4'hD;
  localparam logic [3:0] OP_PCS = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } pc_state_e;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection: fall-through, PC-relative branch, register branch, hold on HLT.
module pc_next_sel
  import wisc_pkg::*;
(
  input  logic [15:0] pc_i,
  input  logic [3:0]  opcode_i,
  input  logic [8:0]  imm9_i,
  input  logic [15:0] br_target_i,
  input  logic        take_branch_i,
  output logic [15:0] pc_plus2_o,
  output logic [15:0] pc_next_o
);

  logic [15:0] br_offset;

  assign pc_plus2_o = pc_i + 16'd2;
  // imm9 counts instruction words; sign-extend and scale to bytes.
  assign br_offset  = {{6{imm9_i[8]}}, imm9_i, 1'b0};

  always_comb begin
    pc_next_o = pc_plus2_o;
    unique case (opcode_i)
      OP_B:    if (take_branch_i) pc_next_o = pc_plus2_o + br_offset;
      OP_BR:   if (take_branch_i) pc_next_o = br_target_i & 16'hFFFE;
      OP_PCS:  pc_next_o = pc_plus2_o;
      OP_HLT:  pc_next_o = pc_i;
      default: pc_next_o = pc_plus2_o;
    endcase
  end

endmodule

// File: rtl/pc_control.sv
// Program counter register and RUN/HALTED FSM with stall hold.
// Optional taken-branch counter built when PC_CONTROL_BRANCH_COUNT_EN is defined.
module pc_control
  import wisc_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  opcode,
  input  logic [8:0]  imm9,
  input  logic [15:0] br_target,
  input  logic        take_branch,
  input  logic        stall,
  output logic [15:0] pc,
  output logic [15:0] pc_plus2,
  output logic        halted
`ifdef PC_CONTROL_BRANCH_COUNT_EN
  ,
  output logic [15:0] taken_cnt
`endif
);

  pc_state_e   state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] pc_next;
  logic        advance;

  pc_next_sel u_next_sel (
    .pc_i          (pc_q),
    .opcode_i      (opcode),
    .imm9_i        (imm9),
    .br_target_i   (br_target),
    .take_branch_i (take_branch),
    .pc_plus2_o    (pc_plus2),
    .pc_next_o     (pc_next)
  );

  assign advance = (state_q == ST_RUN) && !stall;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (advance) begin
      pc_d = pc_next;
      if (opcode == OP_HLT) state_d = ST_HALTED;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign pc     = pc_q;
  assign halted = (state_q == ST_HALTED);

`ifdef PC_CONTROL_BRANCH_COUNT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        redirect;

  assign redirect = take_branch && ((opcode == OP_B) || (opcode == OP_BR));

  always_comb begin
    cnt_d = cnt_q;
    if (advance && redirect && (cnt_q != '1)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign taken_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_pc_control.sv
// Self-checking bench for pc_control against a behavioural PC model.
module tb_pc_control;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  opcode = 4'h0;
  logic [8:0]  imm9 = '0;
  logic [15:0] br_target = '0;
  logic        take_branch = 1'b0;
  logic        stall = 1'b0;
  logic [15:0] pc, pc_plus2;
  logic        halted;
`ifdef PC_CONTROL_BRANCH_COUNT_EN
  logic [15:0] taken_cnt;
`endif

  int checks = 0;
  int errors = 0;

  int m_pc     = 0;
  bit m_halted = 0;
  int m_cnt    = 0;

  always #5 clk = ~clk;

  pc_control #(.RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .imm9        (imm9),
    .br_target   (br_target),
    .take_branch (take_branch),
    .stall       (stall),
    .pc          (pc),
    .pc_plus2    (pc_plus2),
    .halted      (halted)
`ifdef PC_CONTROL_BRANCH_COUNT_EN
    ,
    .taken_cnt   (taken_cnt)
`endif
  );

  // Reference: ISA-level next PC from the instruction rules, plain integer arithmetic.
  task automatic step(input logic [3:0] op, input logic [8:0] imm,
                      input logic [15:0] tgt, input bit tb, input bit st);
    int off;
    opcode = op; imm9 = imm; br_target = tgt; take_branch = tb; stall = st;
    if (!m_halted && !st) begin
      off = (imm >= 256) ? (int'(imm) - 512) : int'(imm);
      if (op == 4'hC && tb) begin
        m_pc = (m_pc + 2 + off * 2) % 65536;
        if (m_pc < 0) m_pc += 65536;
        if (m_cnt < 65535) m_cnt++;
      end else if (op == 4'hD && tb) begin
        m_pc = (tgt / 2) * 2;
        if (m_cnt < 65535) m_cnt++;
      end else if (op == 4'hF) begin
        m_halted = 1;
      end else begin
        m_pc = (m_pc + 2) % 65536;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_pc = 0; m_halted = 0; m_cnt = 0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    opcode = 4'h0; take_branch = 1'b0; stall = 1'b0;
    #2 rst = 1'b1;
    m_pc = 0; m_halted = 0; m_cnt = 0;
    #1;
    checks++;
    if (pc !== 16'h0000 || halted !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: pc=%h halted=%b required pc=0000 halted=0", pc, halted);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step(4'h0, '0, '0, 1'b0, 1'b0);
    checks++;
    if (pc !== 16'h0006) begin
      errors++;
      $display("FAIL reset_3cycles: pc=%h required 0006", pc);
    end
  endtask

  task automatic test_branch_b();
    step(4'hD, '0, 16'h0010, 1'b1, 1'b0);
    checks++;
    if (pc !== 16'h0010) begin
      errors++;
      $display("FAIL br_to_10: pc=%h required 0010", pc);
    end
    step(4'hC, 9'h1FE, '0, 1'b1, 1'b0);
    checks++;
    if (pc !== 16'h000E) begin
      errors++;
      $display("FAIL b_taken_neg: pc=%h required 000e", pc);
    end
    step(4'hD, '0, 16'h0010, 1'b1, 1'b0);
    step(4'hC, 9'h1FE, '0, 1'b0, 1'b0);
    checks++;
    if (pc !== 16'h0012) begin
      errors++;
      $display("FAIL b_not_taken: pc=%h required 0012", pc);
    end
  endtask

  task automatic test_branch_br();
    step(4'hD, '0, 16'h1235, 1'b1, 1'b0);
    checks++;
    if (pc !== 16'h1234) begin
      errors++;
      $display("FAIL br_lsb_clear: pc=%h required 1234", pc);
    end
    step(4'h0, 9'h0FF, 16'hBEEF, 1'b1, 1'b0);
    checks++;
    if (pc !== 16'h1236) begin
      errors++;
      $display("FAIL op0_ignores_tb: pc=%h required 1236", pc);
    end
    checks++;
    if (pc_plus2 !== 16'h1238) begin
      errors++;
      $display("FAIL pc_plus2: got=%h required 1238", pc_plus2);
    end
  endtask

  task automatic test_stall();
    int base;
    int cnt0;
    base = m_pc;
    cnt0 = m_cnt;
    for (int i = 0; i < 2; i++) begin
      step(4'hC, 9'h004, '0, 1'b1, 1'b1);
      checks++;
      if (pc !== 16'(base)) begin
        errors++;
        $display("FAIL stall_hold: pc=%h required %h", pc, 16'(base));
      end
    end
    step(4'hF, '0, '0, 1'b0, 1'b1);
    checks++;
    if (halted !== 1'b0 || pc !== 16'(base)) begin
      errors++;
      $display("FAIL stall_over_hlt: pc=%h halted=%b required %h/0", pc, halted, 16'(base));
    end
`ifdef PC_CONTROL_BRANCH_COUNT_EN
    checks++;
    if (taken_cnt !== 16'(cnt0)) begin
      errors++;
      $display("FAIL stall_cnt: cnt=%h required %h", taken_cnt, 16'(cnt0));
    end
`endif
    step(4'hC, 9'h004, '0, 1'b1, 1'b0);
    checks++;
    if (pc !== 16'((base + 10) % 65536)) begin
      errors++;
      $display("FAIL stall_release: pc=%h required %h", pc, 16'((base + 10) % 65536));
    end
`ifdef PC_CONTROL_BRANCH_COUNT_EN
    checks++;
    if (taken_cnt !== 16'(cnt0 + 1)) begin
      errors++;
      $display("FAIL stall_release_cnt: cnt=%h required %h", taken_cnt, 16'(cnt0 + 1));
    end
`endif
  endtask

  task automatic test_halt();
    step(4'hD, '0, 16'h0020, 1'b1, 1'b0);
    step(4'hF, '0, '0, 1'b0, 1'b0);
    checks++;
    if (halted !== 1'b1 || pc !== 16'h0020) begin
      errors++;
      $display("FAIL halt_enter: pc=%h halted=%b required 0020/1", pc, halted);
    end
    for (int i = 0; i < 5; i++) begin
      step(4'($urandom), 9'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      checks++;
      if (halted !== 1'b1 || pc !== 16'h0020) begin
        errors++;
        $display("FAIL halt_hold: pc=%h halted=%b required 0020/1", pc, halted);
      end
    end
    #2 rst = 1'b1;
    m_pc = 0; m_halted = 0; m_cnt = 0;
    #1;
    checks++;
    if (pc !== 16'h0000 || halted !== 1'b0) begin
      errors++;
      $display("FAIL halt_async_rst: pc=%h halted=%b required 0000/0", pc, halted);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    step(4'h0, '0, '0, 1'b0, 1'b0);
    checks++;
    if (pc !== 16'h0002) begin
      errors++;
      $display("FAIL post_rst_fetch: pc=%h required 0002", pc);
    end
  endtask

  task automatic test_wrap();
    step(4'hD, '0, 16'hFFFE, 1'b1, 1'b0);
    step(4'hE, '0, '0, 1'b1, 1'b0);
    checks++;
    if (pc !== 16'h0000) begin
      errors++;
      $display("FAIL wrap: pc=%h required 0000", pc);
    end
    step(4'hD, '0, 16'h0002, 1'b1, 1'b0);
    step(4'hC, 9'h1FD, '0, 1'b1, 1'b0);
    checks++;
    if (pc !== 16'hFFFE) begin
      errors++;
      $display("FAIL wrap_neg: pc=%h required fffe", pc);
    end
  endtask

  task automatic test_random();
    logic [3:0] op;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      op = 4'($urandom);
      if (op == 4'hF && $urandom_range(0, 19) != 0) op = 4'hC;
      step(op, 9'($urandom), 16'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
      checks++;
      if (pc !== 16'(m_pc) || halted !== m_halted || pc_plus2 !== 16'((m_pc + 2) % 65536)) begin
        errors++;
        $display("FAIL random[%0d]: pc=%h halted=%b p2=%h required %h/%b/%h",
                 i, pc, halted, pc_plus2, 16'(m_pc), m_halted, 16'((m_pc + 2) % 65536));
      end
`ifdef PC_CONTROL_BRANCH_COUNT_EN
      checks++;
      if (taken_cnt !== 16'(m_cnt)) begin
        errors++;
        $display("FAIL random_cnt[%0d]: cnt=%h required %h", i, taken_cnt, 16'(m_cnt));
      end
`endif
    end
    do_reset();
  endtask

`ifdef PC_CONTROL_BRANCH_COUNT_EN
  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 65535; i++) step(4'hD, '0, 16'h0100, 1'b1, 1'b0);
    checks++;
    if (taken_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL cnt_fill: cnt=%h required ffff", taken_cnt);
    end
    step(4'hC, 9'h001, '0, 1'b1, 1'b0);
    checks++;
    if (taken_cnt !== 16'hFFFF || pc !== 16'h0104) begin
      errors++;
      $display("FAIL cnt_saturate: cnt=%h pc=%h required ffff/0104", taken_cnt, pc);
    end
  endtask
`endif

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_branch_b();
    test_branch_br();
    test_stall();
    test_halt();
    test_wrap();
    test_random();
`ifdef PC_CONTROL_BRANCH_COUNT_EN
    test_saturation();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
